// File: rtl/red_pitaya_fads_sort_sched.sv
// FADS sort-pulse scheduler: timestamps sort requests, queues them and fires one
// guarded trigger pulse per request. Define FADS_SORT_SCHED_STATS_EN for statistics counters.
module red_pitaya_fads_sort_sched #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TW         = 32
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rstn_i,
  input  logic                  req_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [TW-1:0]         delay_i,
  input  logic [TW-1:0]         pulse_len_i,
  input  logic [TW-1:0]         guard_i,
  output logic                  sort_trig_o,
  output logic                  busy_o,
  output logic [DEPTH_LOG2:0]   fifo_count_o,
  output logic [TW-1:0]         fired_cnt_o,
  output logic [TW-1:0]         dropped_cnt_o,
  output logic [TW-1:0]         late_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         now_q;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  trig_q, busy_q;
  logic                  full, empty, push, pop, head_due;
  logic [TW-1:0]         head, since_due;

  assign full      = count_q[DEPTH_LOG2];
  assign empty     = (count_q == '0);
  assign push      = req_i & enable_i & ~flush_i & ~full;
  assign head      = mem[rd_ptr_q];
  // Wrap-safe: head is due once the modular distance past it is non-negative.
  assign since_due = now_q - head;
  assign head_due  = ~since_due[TW-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && head_due) begin
          pop     = 1'b1;
          state_d = PULSE;
          cnt_d   = (pulse_len_i == '0) ? TW'(1) : pulse_len_i;
        end
      end
      PULSE: begin
        if (cnt_q == TW'(1)) begin
          cnt_d   = guard_i;
          state_d = (guard_i != '0) ? GUARD : IDLE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      GUARD: begin
        if (cnt_q == TW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      now_q    <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      now_q   <= now_q + TW'(1);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= (state_d == PULSE);
      busy_q  <= (state_d != IDLE);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
          2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (push) mem[wr_ptr_q] <= now_q + delay_i;
  end

  assign sort_trig_o  = trig_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

`ifdef FADS_SORT_SCHED_STATS_EN
  logic          drop, late;
  logic [TW-1:0] fired_q, dropped_q, late_q;

  // Full is judged on the count before any same-cycle pop.
  assign drop = req_i & enable_i & ~flush_i & full;
  assign late = (now_q != head);

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      fired_q   <= '0;
      dropped_q <= '0;
      late_q    <= '0;
    end else begin
      if (pop && fired_q != '1)         fired_q   <= fired_q + TW'(1);
      if (pop && late && late_q != '1)  late_q    <= late_q + TW'(1);
      if (drop && dropped_q != '1)      dropped_q <= dropped_q + TW'(1);
    end
  end

  assign fired_cnt_o   = fired_q;
  assign dropped_cnt_o = dropped_q;
  assign late_cnt_o    = late_q;
`else
  assign fired_cnt_o   = '0;
  assign dropped_cnt_o = '0;
  assign late_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
// Bench for red_pitaya_fads_sort_sched: directed and random requests against an
// interval-based schedule model (pop cycle, pulse window, guard window per entry).
`timescale 1ns/1ps
module tb_red_pitaya_fads_sort_sched;

  localparam int DEPTH    = 8;
  localparam int MAXE     = 2048;
  localparam int CUT_NONE = 32'h7fffffff;
`ifdef FADS_SORT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, en = 1'b0, flush = 1'b0, req_w = 1'b0;
  logic [31:0] delay = '0, plen = '0, guard = '0;
  logic [7:0]  delay_w = '0;

  logic        sort_trig_o, busy_o;
  logic [3:0]  fifo_count_o;
  logic [31:0] fired_cnt_o, dropped_cnt_o, late_cnt_o;
  logic        trig_w, busy_w;
  logic [3:0]  count_w;
  logic [7:0]  fired_w, dropped_w, late_w;

  red_pitaya_fads_sort_sched #(.DEPTH_LOG2(3), .TW(32)) dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .req_i(req), .enable_i(en), .flush_i(flush),
    .delay_i(delay), .pulse_len_i(plen), .guard_i(guard),
    .sort_trig_o(sort_trig_o), .busy_o(busy_o), .fifo_count_o(fifo_count_o),
    .fired_cnt_o(fired_cnt_o), .dropped_cnt_o(dropped_cnt_o), .late_cnt_o(late_cnt_o)
  );

  // Narrow-timestamp instance: exercises counter wrap and saturation in few cycles.
  red_pitaya_fads_sort_sched #(.DEPTH_LOG2(3), .TW(8)) dut_w (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .req_i(req_w), .enable_i(1'b1), .flush_i(1'b0),
    .delay_i(delay_w), .pulse_len_i(plen[7:0]), .guard_i(guard[7:0]),
    .sort_trig_o(trig_w), .busy_o(busy_w), .fifo_count_o(count_w),
    .fired_cnt_o(fired_w), .dropped_cnt_o(dropped_w), .late_cnt_o(late_w)
  );

  always #4 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_ent = 0, drops = 0, idle_ready = 0;
  int e_push[MAXE], e_due[MAXE], e_pop[MAXE], e_len[MAXE], e_grd[MAXE], e_cut[MAXE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    n_ent = 0; drops = 0; idle_ready = 0;
  endtask

  task automatic model_req(input int t, input int d);
    int occ;
    int lq;
    int p;
    occ = 0;
    for (int i = 0; i < n_ent; i++) if (e_pop[i] >= t) occ++;
    if (occ >= DEPTH) begin
      drops++;
    end else begin
      lq = (plen == 0) ? 1 : int'(plen);
      p = t + 1;
      if (t + d > p) p = t + d;
      if (idle_ready > p) p = idle_ready;
      e_push[n_ent] = t; e_due[n_ent] = t + d; e_pop[n_ent] = p;
      e_len[n_ent] = lq; e_grd[n_ent] = int'(guard); e_cut[n_ent] = CUT_NONE;
      n_ent++;
      idle_ready = p + lq + int'(guard) + 1;
    end
  endtask

  task automatic model_flush(input int k);
    int keep;
    keep = 0;
    for (int i = 0; i < n_ent; i++) if (e_pop[i] < k) keep = i + 1;
    n_ent = keep;
    for (int i = 0; i < n_ent; i++) if (e_cut[i] > k) e_cut[i] = k;
    idle_ready = k + 1;
  endtask

  function automatic int exp_trig(input int x);
    for (int i = 0; i < n_ent; i++)
      if (x >= e_pop[i] + 1 && x <= e_pop[i] + e_len[i] && x <= e_cut[i]) return 1;
    return 0;
  endfunction

  function automatic int exp_busy(input int x);
    for (int i = 0; i < n_ent; i++)
      if (x >= e_pop[i] + 1 && x <= e_pop[i] + e_len[i] + e_grd[i] && x <= e_cut[i]) return 1;
    return 0;
  endfunction

  function automatic int exp_count(input int x);
    int n;
    n = 0;
    for (int i = 0; i < n_ent; i++) if (e_push[i] <= x - 1 && e_pop[i] > x - 1) n++;
    return n;
  endfunction

  function automatic int exp_fired(input int x);
    int n;
    n = 0;
    for (int i = 0; i < n_ent; i++) if (e_pop[i] <= x - 1) n++;
    return STATS ? n : 0;
  endfunction

  function automatic int exp_late(input int x);
    int n;
    n = 0;
    for (int i = 0; i < n_ent; i++) if (e_pop[i] <= x - 1 && e_pop[i] != e_due[i]) n++;
    return STATS ? n : 0;
  endfunction

  // Apply current inputs for cycle cyc, clock once, then check the following cycle.
  task automatic step();
    if (req && en && !flush) model_req(cyc, int'(delay));
    if (flush) model_flush(cyc);
    @(posedge clk); #1;
    cyc++;
    chk("trig",    sort_trig_o,   exp_trig(cyc));
    chk("busy",    busy_o,        exp_busy(cyc));
    chk("count",   fifo_count_o,  exp_count(cyc));
    chk("fired",   fired_cnt_o,   exp_fired(cyc));
    chk("late",    late_cnt_o,    exp_late(cyc));
    chk("dropped", dropped_cnt_o, STATS ? drops : 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_trig"},    sort_trig_o,   0);
    chk({tag, "_busy"},    busy_o,        0);
    chk({tag, "_count"},   fifo_count_o,  0);
    chk({tag, "_fired"},   fired_cnt_o,   0);
    chk({tag, "_dropped"}, dropped_cnt_o, 0);
    chk({tag, "_late"},    late_cnt_o,    0);
  endtask

  initial begin
    int t0, rise, width, pulses, fired_snap;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");
    rst_n = 1'b1; cyc = 0; model_clear();
    en = 1'b1;
    repeat (4) step();

    // Single request: delay 100, 10-cycle pulse, guard 5.
    plen = 10; guard = 5; delay = 100;
    t0 = cyc; req = 1'b1; step(); req = 1'b0;
    rise = -1; width = 0;
    repeat (125) begin
      step();
      if (sort_trig_o && rise < 0) rise = cyc;
      if (sort_trig_o) width++;
    end
    chk("single_rise", rise, t0 + 101);
    chk("single_width", width, 10);

    // Nine back-to-back requests into an 8-deep FIFO.
    plen = 4; guard = 3; delay = 1000;
    req = 1'b1; repeat (9) step(); req = 1'b0;
    chk("burst_full", fifo_count_o, 8);
    pulses = 0; prev = 1'b0;
    repeat (1100) begin
      step();
      if (sort_trig_o && !prev) pulses++;
      prev = sort_trig_o;
    end
    chk("burst_pulses", pulses, 8);

    // Zero pulse length and guard, two requests due one cycle apart.
    plen = 0; guard = 0; delay = 5;
    req = 1'b1; repeat (2) step(); req = 1'b0;
    repeat (15) step();

    // Timestamp wrap on the 8-bit instance: request at now=206, delay 100.
    plen = 2; guard = 1;
    repeat ((206 - (cyc % 256) + 256) % 256) step();
    delay_w = 8'd100; t0 = cyc; req_w = 1'b1; step(); req_w = 1'b0;
    rise = -1;
    repeat (110) begin
      step();
      if (trig_w && rise < 0) rise = cyc;
    end
    chk("wrap_rise", rise, t0 + 101);

    // Random traffic in three parameter phases, each drained before the next.
    for (int ph = 0; ph < 3; ph++) begin
      plen = $urandom_range(0, 4); guard = $urandom_range(0, 3);
      for (int i = 0; i < 300; i++) begin
        req = ($urandom_range(0, 3) == 0);
        en = ($urandom_range(0, 7) != 0);
        delay = $urandom_range(0, 40);
        step();
      end
      req = 1'b0; en = 1'b1;
      repeat (400) step();
    end

    // Flush in the third cycle of a 10-cycle pulse with 3 entries queued and a request.
    plen = 10; guard = 2;
    delay = 2; req = 1'b1; step();
    delay = 1000; repeat (3) step();
    req = 1'b0; step();
    chk("flush_pre_trig", sort_trig_o, 1);
    chk("flush_pre_count", fifo_count_o, 3);
    fired_snap = exp_fired(cyc);
    flush = 1'b1; req = 1'b1; step();
    flush = 1'b0; req = 1'b0;
    chk("flush_trig", sort_trig_o, 0);
    chk("flush_count", fifo_count_o, 0);
    chk("flush_busy", busy_o, 0);
    chk("flush_fired", fired_cnt_o, fired_snap);
    repeat (30) step();

    // Counter saturation on the 8-bit instance: 300 on-time pulses.
    plen = 1; guard = 0; delay_w = 8'd1;
    for (int i = 0; i < 300; i++) begin
      req_w = 1'b1; step(); req_w = 1'b0; step(); step();
    end
    repeat (5) step();
    chk("sat_fired_w", fired_w, STATS ? 255 : 0);
    chk("sat_late_w", late_w, 0);
    chk("sat_dropped_w", dropped_w, 0);
    chk("sat_count_w", count_w, 0);
    chk("sat_busy_w", busy_w, 0);

    // Asynchronous reset in the middle of a pulse.
    plen = 10; guard = 0; delay = 3;
    req = 1'b1; step(); req = 1'b0;
    repeat (6) step();
    chk("rst_pre_trig", sort_trig_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_trig", sort_trig_o, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst1");
    rst_n = 1'b1; cyc = 0; model_clear();
    plen = 3; guard = 1; delay = 4;
    req = 1'b1; step(); req = 1'b0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
